// File: rtl/raster_pkg.sv
// Shared raster definitions: screen defaults, scanner states and the 128-bit triangle layout.
package raster_pkg;

    localparam int unsigned H_RES_DEF = 320;
    localparam int unsigned V_RES_DEF = 240;

    localparam int unsigned CW     = 16;   // triangle field width
    localparam int unsigned TRI_W  = 128;
    localparam int unsigned XW     = 9;
    localparam int unsigned YW     = 8;
    localparam int unsigned AW     = 17;
    localparam int unsigned AREA_W = 33;

    // Field offsets: color|p1x|p1y|p2x|p2y|p3x|p3y|depth, color in the top bits
    localparam int unsigned COLOR_LSB = 112;
    localparam int unsigned P1X_LSB   = 96;
    localparam int unsigned P1Y_LSB   = 80;
    localparam int unsigned P2X_LSB   = 64;
    localparam int unsigned P2Y_LSB   = 48;
    localparam int unsigned P3X_LSB   = 32;
    localparam int unsigned P3Y_LSB   = 16;
    localparam int unsigned DEPTH_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic logic signed [CW-1:0] tri_field(input logic [TRI_W-1:0] t,
                                                       input int unsigned lsb);
        return $signed(t[lsb +: CW]);
    endfunction

endpackage

// File: rtl/bbox_clamp.sv
// Combinational bounding box of three signed vertices, clamped to the screen, with an
// empty flag for boxes lying entirely off-screen.
module bbox_clamp
    import raster_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF
) (
    input  logic signed [CW-1:0] x1,
    input  logic signed [CW-1:0] y1,
    input  logic signed [CW-1:0] x2,
    input  logic signed [CW-1:0] y2,
    input  logic signed [CW-1:0] x3,
    input  logic signed [CW-1:0] y3,
    output logic [XW-1:0]        x_lo,
    output logic [XW-1:0]        x_hi,
    output logic [YW-1:0]        y_lo,
    output logic [YW-1:0]        y_hi,
    output logic                 empty
);

    localparam int unsigned EW = CW + 1;
    localparam logic signed [EW-1:0] X_LIM = EW'(H_RES);
    localparam logic signed [EW-1:0] Y_LIM = EW'(V_RES);

    logic signed [CW-1:0] xmin, xmax, ymin, ymax;
    logic signed [EW-1:0] xmin_e, xmax_e, ymin_e, ymax_e;

    always_comb begin
        xmin = x1;
        xmax = x1;
        ymin = y1;
        ymax = y1;
        if (x2 < xmin) xmin = x2;
        if (x3 < xmin) xmin = x3;
        if (x2 > xmax) xmax = x2;
        if (x3 > xmax) xmax = x3;
        if (y2 < ymin) ymin = y2;
        if (y3 < ymin) ymin = y3;
        if (y2 > ymax) ymax = y2;
        if (y3 > ymax) ymax = y3;

        xmin_e = EW'(xmin);
        xmax_e = EW'(xmax);
        ymin_e = EW'(ymin);
        ymax_e = EW'(ymax);

        // Empty uses the unclamped extremes so a box wholly off one edge never scans
        empty = xmax[CW-1] || ymax[CW-1] || (xmin_e >= X_LIM) || (ymin_e >= Y_LIM);

        x_lo = xmin[CW-1] ? '0 : XW'(xmin);
        y_lo = ymin[CW-1] ? '0 : YW'(ymin);
        x_hi = (xmax_e >= X_LIM) ? XW'(H_RES - 1) : XW'(xmax);
        y_hi = (ymax_e >= Y_LIM) ? YW'(V_RES - 1) : YW'(ymax);
    end

endmodule

// File: rtl/triangle_scanner.sv
// Scans the clamped bounding box of a triangle in row-major order, reading the framebuffer
// and presenting each pixel FB_LATENCY cycles later. TRIANGLE_SCANNER_CULL_EN drops zero-area triangles.
module triangle_scanner
    import raster_pkg::*;
#(
    parameter int unsigned H_RES      = H_RES_DEF,
    parameter int unsigned V_RES      = V_RES_DEF,
    parameter int unsigned FB_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TRI_W-1:0]  tri_in,
    input  logic              tri_valid_in,
    output logic              tri_ready_out,
    output logic [AW-1:0]     fb_addr_out,
    output logic              fb_rd_en_out,
    input  logic [31:0]       fb_data_in,
    output logic [XW-1:0]     xcoord_out,
    output logic [YW-1:0]     ycoord_out,
    output logic [31:0]       pixel_data_out,
    output logic [TRI_W-1:0]  triangle_out,
    output logic              pixel_out_valid,
    output logic              busy_out
);

    localparam int unsigned DW = 3;

    state_t state, state_d;

    logic [TRI_W-1:0] tri_d;
    logic [XW-1:0]    xlo_q, xhi_q, xlo_d, xhi_d, cur_x, x_d;
    logic [YW-1:0]    yhi_q, yhi_d, cur_y, y_d;
    logic [AW-1:0]    wrap_q, wrap_d, addr_d;
    logic [DW-1:0]    drain_cnt, drain_d;
    logic             rd_d, ready_d, busy_d;

    logic [XW-1:0] bx_lo, bx_hi;
    logic [YW-1:0] by_lo, by_hi;
    logic          bb_empty, cull, box_empty;

    logic          pv [FB_LATENCY];
    logic [XW-1:0] px [FB_LATENCY];
    logic [YW-1:0] py [FB_LATENCY];

    bbox_clamp #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_bbox (
        .x1    (tri_field(triangle_out, P1X_LSB)),
        .y1    (tri_field(triangle_out, P1Y_LSB)),
        .x2    (tri_field(triangle_out, P2X_LSB)),
        .y2    (tri_field(triangle_out, P2Y_LSB)),
        .x3    (tri_field(triangle_out, P3X_LSB)),
        .y3    (tri_field(triangle_out, P3Y_LSB)),
        .x_lo  (bx_lo),
        .x_hi  (bx_hi),
        .y_lo  (by_lo),
        .y_hi  (by_hi),
        .empty (bb_empty)
    );

`ifdef TRIANGLE_SCANNER_CULL_EN
    logic signed [AREA_W-1:0] ex1, ey1, ex2, ey2, area;

    // Twice the signed area; zero means the vertices are collinear
    always_comb begin
        ex1  = AREA_W'(tri_field(triangle_out, P2X_LSB)) - AREA_W'(tri_field(triangle_out, P1X_LSB));
        ey1  = AREA_W'(tri_field(triangle_out, P2Y_LSB)) - AREA_W'(tri_field(triangle_out, P1Y_LSB));
        ex2  = AREA_W'(tri_field(triangle_out, P3X_LSB)) - AREA_W'(tri_field(triangle_out, P1X_LSB));
        ey2  = AREA_W'(tri_field(triangle_out, P3Y_LSB)) - AREA_W'(tri_field(triangle_out, P1Y_LSB));
        area = AREA_W'(ex1 * ey2) - AREA_W'(ey1 * ex2);
        cull = (area == '0);
    end
`else
    assign cull = 1'b0;
`endif

    assign box_empty = bb_empty | cull;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_d;
    end

    // Next state and next datapath values
    always_comb begin
        state_d = state;
        tri_d   = triangle_out;
        xlo_d   = xlo_q;
        xhi_d   = xhi_q;
        yhi_d   = yhi_q;
        wrap_d  = wrap_q;
        x_d     = cur_x;
        y_d     = cur_y;
        addr_d  = fb_addr_out;
        rd_d    = 1'b0;
        drain_d = drain_cnt;

        case (state)
            ST_IDLE: begin
                if (tri_valid_in && tri_ready_out) begin
                    tri_d   = tri_in;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (box_empty) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SCAN;
                    xlo_d   = bx_lo;
                    xhi_d   = bx_hi;
                    yhi_d   = by_hi;
                    // Row wrap step: back to xmin on the next line
                    wrap_d  = AW'(H_RES) - AW'(bx_hi - bx_lo);
                    x_d     = bx_lo;
                    y_d     = by_lo;
                    addr_d  = AW'(AW'(by_lo) * AW'(H_RES)) + AW'(bx_lo);
                    rd_d    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (cur_x == xhi_q) begin
                    if (cur_y == yhi_q) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        rd_d   = 1'b1;
                        x_d    = xlo_q;
                        y_d    = cur_y + YW'(1);
                        addr_d = fb_addr_out + wrap_q;
                    end
                end else begin
                    rd_d   = 1'b1;
                    x_d    = cur_x + XW'(1);
                    addr_d = fb_addr_out + AW'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DW'(FB_LATENCY - 1)) state_d = ST_IDLE;
                else                                  drain_d = drain_cnt + DW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Datapath and read-delay pipeline
    always_ff @(posedge clk) begin
        if (!rst) begin
            triangle_out  <= '0;
            xlo_q         <= '0;
            xhi_q         <= '0;
            yhi_q         <= '0;
            wrap_q        <= '0;
            cur_x         <= '0;
            cur_y         <= '0;
            fb_addr_out   <= '0;
            fb_rd_en_out  <= 1'b0;
            drain_cnt     <= '0;
            tri_ready_out <= 1'b0;
            busy_out      <= 1'b0;
            for (int i = 0; i < FB_LATENCY; i++) begin
                pv[i] <= 1'b0;
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            triangle_out  <= tri_d;
            xlo_q         <= xlo_d;
            xhi_q         <= xhi_d;
            yhi_q         <= yhi_d;
            wrap_q        <= wrap_d;
            cur_x         <= x_d;
            cur_y         <= y_d;
            fb_addr_out   <= addr_d;
            fb_rd_en_out  <= rd_d;
            drain_cnt     <= drain_d;
            tri_ready_out <= ready_d;
            busy_out      <= busy_d;
            pv[0]         <= fb_rd_en_out;
            px[0]         <= cur_x;
            py[0]         <= cur_y;
            for (int i = 1; i < FB_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
    end

    assign pixel_out_valid = pv[FB_LATENCY-1];
    assign xcoord_out      = px[FB_LATENCY-1];
    assign ycoord_out      = py[FB_LATENCY-1];
    // Read data lands in the same cycle as the delayed strobe, so it passes straight through
    assign pixel_data_out  = pixel_out_valid ? fb_data_in : 32'h0;

endmodule

// File: tb/tb_triangle_scanner.sv
// Self-checking bench for triangle_scanner: directed corner cases plus random triangles
// scored against a bounding-box reference model and a latency-accurate framebuffer model.
module tb_triangle_scanner;

    localparam int L = 2;
    localparam int H = 320;
    localparam int V = 240;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] tri_in;
    logic         tri_valid_in;
    logic         tri_ready_out;
    logic [16:0]  fb_addr_out;
    logic         fb_rd_en_out;
    logic [31:0]  fb_data_in;
    logic [8:0]   xcoord_out;
    logic [7:0]   ycoord_out;
    logic [31:0]  pixel_data_out;
    logic [127:0] triangle_out;
    logic         pixel_out_valid;
    logic         busy_out;

    triangle_scanner #(.H_RES(H), .V_RES(V), .FB_LATENCY(L)) dut (
        .clk             (clk),
        .rst             (rst),
        .tri_in          (tri_in),
        .tri_valid_in    (tri_valid_in),
        .tri_ready_out   (tri_ready_out),
        .fb_addr_out     (fb_addr_out),
        .fb_rd_en_out    (fb_rd_en_out),
        .fb_data_in      (fb_data_in),
        .xcoord_out      (xcoord_out),
        .ycoord_out      (ycoord_out),
        .pixel_data_out  (pixel_data_out),
        .triangle_out    (triangle_out),
        .pixel_out_valid (pixel_out_valid),
        .busy_out        (busy_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Framebuffer: contents are a fixed function of the address, returned L cycles after the strobe
    function automatic logic [31:0] fb_word(input logic [16:0] a);
        logic [16:0] v;
        v = a;
        return {v[15:0] ^ 16'h5A3C, {v[16], v[14:0]} + 16'h1357};
    endfunction

    logic [16:0] mp_addr [L];
    logic        mp_en   [L];
    always @(posedge clk) begin
        mp_en[0]   <= fb_rd_en_out;
        mp_addr[0] <= fb_addr_out;
        for (int i = 1; i < L; i++) begin
            mp_en[i]   <= mp_en[i-1];
            mp_addr[i] <= mp_addr[i-1];
        end
    end
    assign fb_data_in = mp_en[L-1] ? fb_word(mp_addr[L-1]) : 32'hDEADBEEF;

    function automatic logic [127:0] mk(input int c, input int ax, input int ay, input int bx,
                                        input int by, input int qx, input int qy, input int d);
        return {16'(c), 16'(ax), 16'(ay), 16'(bx), 16'(by), 16'(qx), 16'(qy), 16'(d)};
    endfunction

    // Reference: clamped bounding box of the three vertices, or empty
    function automatic void bbox(input logic [127:0] t, output int xlo, output int xhi,
                                 output int ylo, output int yhi, output bit empty);
        logic [127:0] v;
        int xs[3], ys[3];
        int xmin, xmax, ymin, ymax;
        v = t;
        xs[0] = int'($signed(v[111:96])); ys[0] = int'($signed(v[95:80]));
        xs[1] = int'($signed(v[79:64]));  ys[1] = int'($signed(v[63:48]));
        xs[2] = int'($signed(v[47:32]));  ys[2] = int'($signed(v[31:16]));
        xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
        for (int i = 1; i < 3; i++) begin
            if (xs[i] < xmin) xmin = xs[i];
            if (xs[i] > xmax) xmax = xs[i];
            if (ys[i] < ymin) ymin = ys[i];
            if (ys[i] > ymax) ymax = ys[i];
        end
        empty = (xmax < 0) || (ymax < 0) || (xmin >= H) || (ymin >= V);
`ifdef TRIANGLE_SCANNER_CULL_EN
        if (longint'(xs[1] - xs[0]) * longint'(ys[2] - ys[0]) ==
            longint'(ys[1] - ys[0]) * longint'(xs[2] - xs[0])) empty = 1'b1;
`endif
        xlo = (xmin < 0) ? 0 : xmin;
        ylo = (ymin < 0) ? 0 : ymin;
        xhi = (xmax > H - 1) ? H - 1 : xmax;
        yhi = (ymax > V - 1) ? V - 1 : ymax;
    endfunction

    function automatic int exp_count(input logic [127:0] t);
        int xlo, xhi, ylo, yhi;
        bit e;
        bbox(t, xlo, xhi, ylo, yhi, e);
        return e ? 0 : (xhi - xlo + 1) * (yhi - ylo + 1);
    endfunction

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [16:0] a;
    } pix_t;

    pix_t         exp_rd[$];
    pix_t         exp_px[$];
    int           rd_cyc[$];
    logic [127:0] cur_tri;
    int           cyc = 0;
    int           px_cnt = 0;
    int           rd_cnt = 0;
    int           lat;
    pix_t         p;

    task automatic add_tri(input logic [127:0] t);
        int xlo, xhi, ylo, yhi;
        bit e;
        pix_t q;
        bbox(t, xlo, xhi, ylo, yhi, e);
        if (!e) begin
            for (int y = ylo; y <= yhi; y++) begin
                for (int x = xlo; x <= xhi; x++) begin
                    q.x = 9'(x);
                    q.y = 8'(y);
                    q.a = 17'(y * H + x);
                    exp_rd.push_back(q);
                    exp_px.push_back(q);
                end
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scores reads, pixels and acceptances against the model
    always @(negedge clk) begin
        if (!rst) begin
            exp_rd.delete();
            exp_px.delete();
            rd_cyc.delete();
        end else begin
            if (fb_rd_en_out) begin
                rd_cnt++;
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 128'(fb_rd_en_out), 128'(0));
                end else begin
                    p = exp_rd.pop_front();
                    chk("rd_addr", 128'(fb_addr_out), 128'(p.a));
                    rd_cyc.push_back(cyc);
                end
            end
            if (pixel_out_valid) begin
                px_cnt++;
                if (exp_px.size() == 0 || rd_cyc.size() == 0) begin
                    chk("px_unexpected", 128'(pixel_out_valid), 128'(0));
                end else begin
                    p   = exp_px.pop_front();
                    lat = cyc - rd_cyc.pop_front();
                    chk("px_xy", 128'({xcoord_out, ycoord_out}), 128'({p.x, p.y}));
                    chk("px_data", 128'(pixel_data_out), 128'(fb_word(p.a)));
                    chk("px_latency", 128'(lat), 128'(L));
                    chk("px_triangle", triangle_out, cur_tri);
                end
            end
            if (tri_ready_out) chk("ready_while_busy", 128'(busy_out), 128'(0));
            if (tri_valid_in && tri_ready_out) begin
                chk("accept_before_drain", 128'(exp_px.size()), 128'(0));
                add_tri(tri_in);
                cur_tri = tri_in;
            end
        end
    end

    task automatic send(input logic [127:0] t, input bit hold);
        bit acc;
        acc = 1'b0;
        tri_in = t;
        tri_valid_in = 1'b1;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            acc = tri_ready_out;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 128'(acc), 128'(1));
        if (!hold) tri_valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(tri_ready_out && exp_px.size() == 0 && exp_rd.size() == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 128'(n), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {90'(0), tri_ready_out, fb_rd_en_out, fb_addr_out, xcoord_out, ycoord_out,
                  pixel_out_valid, busy_out}, 128'(0));
        chk(tag, triangle_out, 128'(0));
        chk(tag, 128'(pixel_data_out), 128'(0));
    endtask

    task automatic run_one(input string tag, input logic [127:0] t, input int want);
        int base;
        base = px_cnt;
        send(t, 1'b0);
        wait_idle();
        chk(tag, 128'(px_cnt - base), 128'(want));
    endtask

    initial begin
        int base;
        int rbase;
        logic [127:0] t;
        rst = 1'b0;
        tri_valid_in = 1'b0;
        tri_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_outputs");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", 128'(tri_ready_out), 128'(1));
        @(posedge clk);
        #1;

        run_one("small_count", mk(16'h1234, 10, 10, 12, 10, 10, 11, 7), 6);
        run_one("clamp_count", mk(16'h00FF, -5, -5, 2, -3, -1, 1, 3), 6);

        // Off-screen box: no reads, ready returns two cycles after acceptance
        rbase = rd_cnt;
        send(mk(16'h0F0F, 400, 10, 500, 20, 450, 30, 1), 1'b0);
        @(negedge clk);
        chk("offscreen_setup_busy", 128'({tri_ready_out, busy_out}), 128'(2'b01));
        @(posedge clk);
        @(negedge clk);
        chk("offscreen_ready", 128'({tri_ready_out, busy_out}), 128'(2'b10));
        repeat (4) @(posedge clk);
        #1;
        chk("offscreen_reads", 128'(rd_cnt - rbase), 128'(0));

`ifdef TRIANGLE_SCANNER_CULL_EN
        run_one("collinear_count", mk(16'h7777, 0, 0, 1, 1, 2, 2, 9), 0);
`else
        run_one("collinear_count", mk(16'h7777, 0, 0, 1, 1, 2, 2, 9), 9);
`endif

        // Reset on the third SCAN cycle of a 4x4 box
        send(mk(16'hAAAA, 20, 20, 23, 20, 20, 23, 5), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("in_scan_before_reset", 128'(fb_rd_en_out), 128'(1));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("midscan_reset_outputs");
        @(posedge clk);
        #1 rst = 1'b1;
        base = px_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("no_px_after_reset", 128'(px_cnt - base), 128'(0));
        run_one("rescan_count", mk(16'hAAAA, 20, 20, 23, 20, 20, 23, 5), 16);

        // Back-to-back with valid held high
        base = px_cnt;
        send(mk(16'h1111, 30, 5, 32, 5, 30, 6, 2), 1'b1);
        send(mk(16'h2222, 50, 50, 53, 50, 50, 51, 4), 1'b0);
        chk("b2b_first_count", 128'(px_cnt - base), 128'(6));
        wait_idle();
        chk("b2b_total_count", 128'(px_cnt - base), 128'(14));

        // Random triangles near and across the screen edges
        for (int k = 0; k < 25; k++) begin
            int bx, by;
            bx = int'($urandom_range(0, 400)) - 40;
            by = int'($urandom_range(0, 320)) - 40;
            t = mk(int'($urandom), bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)),
                   bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)),
                   bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)), int'($urandom));
            run_one("random_count", t, exp_count(t));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        chk("leftover_reads", 128'(exp_rd.size()), 128'(0));
        chk("leftover_pixels", 128'(exp_px.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/triangle_scanner.md
TRIANGLE_SCANNER -- requirements
Module: triangle_scanner

Interface
REQ-001 SHALL have parameter H_RES, default 320: screen width in pixels.
REQ-002 SHALL have parameter V_RES, default 240: screen height in pixels.
REQ-003 SHALL have parameter FB_LATENCY, default 2: framebuffer read latency in cycles, legal range 1..4.
REQ-004 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port tri_in, input, 128: triangle in the form color|p1x|p1y|p2x|p2y|p3x|p3y|depth, 16 bits each, coordinates signed.
REQ-007 SHALL have port tri_valid_in, input, 1: tri_in is valid.
REQ-008 SHALL have port tri_ready_out, output, 1: the block accepts tri_in this cycle.
REQ-009 SHALL have port fb_addr_out, output, 17: framebuffer read address.
REQ-010 SHALL have port fb_rd_en_out, output, 1: framebuffer read strobe.
REQ-011 SHALL have port fb_data_in, input, 32: read data, color[31:16] and depth[15:0], arriving FB_LATENCY cycles after the strobe.
REQ-012 SHALL have port xcoord_out, output, 9: pixel x.
REQ-013 SHALL have port ycoord_out, output, 8: pixel y.
REQ-014 SHALL have port pixel_data_out, output, 32: the stored color and depth at (x,y).
REQ-015 SHALL have port triangle_out, output, 128: the triangle currently being scanned.
REQ-016 SHALL have port pixel_out_valid, output, 1: the pixel outputs are valid this cycle.
REQ-017 SHALL have port busy_out, output, 1: a triangle is in flight.

Function
REQ-018 SHALL implement the states IDLE, SETUP, SCAN and DRAIN.
REQ-019 SHALL assert tri_ready_out only in IDLE.
REQ-020 SHALL capture tri_in into an internal register on tri_valid_in && tri_ready_out, then go IDLE->SETUP.
REQ-021 SHALL, in SETUP (one cycle), compute the signed min and max of x and y over the three vertices.
REQ-022 SHALL clamp the bounding box to x in [0,H_RES-1] and y in [0,V_RES-1].
REQ-023 SHALL treat the box as empty if the unclamped max < 0, or the unclamped min >= the screen limit, on either axis; an empty box goes SETUP->IDLE with no reads.
REQ-024 SHALL go SETUP->SCAN for a non-empty box, starting at (xmin,ymin).
REQ-025 SHALL, in SCAN, issue one read per cycle in row-major order: x increments, and at xmax wraps to xmin with y+1.
REQ-026 SHALL compute fb_addr_out = y*H_RES + x incrementally, with no multiplier in the scan loop.
REQ-027 SHALL go SCAN->DRAIN after issuing the read for (xmax,ymax).
REQ-028 SHALL stay in DRAIN exactly FB_LATENCY cycles, then return to IDLE.
REQ-029 SHALL delay x, y and the read strobe through a FB_LATENCY-deep shift register.
REQ-030 SHALL present pixel_out_valid, xcoord_out, ycoord_out and pixel_data_out = fb_data_in in the same cycle, exactly FB_LATENCY cycles after the corresponding read.
REQ-031 SHALL hold triangle_out stable from SETUP until the last pixel_out_valid.
REQ-032 SHALL assert busy_out in SETUP, SCAN and DRAIN.
REQ-033 SHALL give a single-pixel box exactly one output pulse.
REQ-034 SHALL emit exactly (xmax-xmin+1)*(ymax-ymin+1) valid pixels per triangle, with no gaps.
REQ-035 SHALL ignore tri_valid_in outside IDLE; the upstream holds the triangle until it sees tri_ready_out.

Reset
REQ-036 SHALL, while rst=0, force state IDLE and clear the delay pipeline.
REQ-037 SHALL reset every output to 0: tri_ready_out, fb_rd_en_out, fb_addr_out, xcoord_out, ycoord_out, pixel_data_out, triangle_out, pixel_out_valid and busy_out.
REQ-038 SHALL, on reset mid-SCAN or mid-DRAIN, abandon the triangle and emit no further valid pixels.
REQ-039 SHALL assert tri_ready_out in the first cycle after rst returns to 1.

Configuration
REQ-040 SHALL, with TRIANGLE_SCANNER_CULL_EN defined, compute in SETUP the signed 33-bit twice-area (p2-p1)x(p3-p1).
REQ-041 SHALL, with TRIANGLE_SCANNER_CULL_EN defined, treat a zero twice-area (degenerate triangle) as an empty box.
REQ-042 SHALL, without TRIANGLE_SCANNER_CULL_EN, compute no area and scan degenerate triangles normally.

Structure
REQ-043 SHALL take H_RES/V_RES defaults, the state enum and the triangle field-offset constants from the shared package raster_pkg.
REQ-044 SHALL contain one sub-module, bbox_clamp: combinational min/max, clamp and empty flag.

Verification
REQ-045 SHALL cover: triangle (10,10),(12,10),(10,11), FB_LATENCY=2 -> 6 valid pixels (10..12,10..11) in row-major order, first valid 2 cycles after the first read, address of (12,11) = 3532.
REQ-046 SHALL cover: triangle (-5,-5),(2,-3),(-1,1) -> box clamped to x 0..2, y 0..1, 6 pixels, first address 0.
REQ-047 SHALL cover: triangle (400,10),(500,20),(450,30) -> no reads, back in IDLE after SETUP, tri_ready_out high 2 cycles after acceptance.
REQ-048 SHALL cover: collinear triangle (0,0),(1,1),(2,2) -> with CULL_EN 0 pixels; without it 9 pixels.
REQ-049 SHALL cover: rst=0 on the third SCAN cycle of a 4x4 box -> all outputs 0 next cycle, no pixel_out_valid afterwards, next triangle scanned correctly.
REQ-050 SHALL cover: back-to-back tri_valid_in held high -> second triangle accepted only after DRAIN; the pixel counts of both triangles are exact.
